key_entry_controller: RTL



---
 rtl/key_entry_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_entry_controller.sv
// key_entry_controller
//   Operand-entry front end for the keyboard calculator. Turns decoder key
//   events into two 2-digit BCD operands, an operator code and a completion
//   strobe. Handles typematic-repeat filtering, backspace and escape.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-high
//   last_change   most recent scan code (bit 8 = E0-extended)
//   key_down      held-key bitmap indexed by scan code
//   key_valid     decoder event flag
//   a_hi, a_lo    operand A tens / ones (BCD)
//   b_hi, b_lo    operand B tens / ones (BCD)
//   op            00 add, 01 subtract, 10 multiply
//   phase         00 S_A, 01 S_B, 10 S_DONE
//   done          high while in S_DONE
//   result_valid  one-cycle pulse on entry into S_DONE
//
// state  | meaning
// S_A    | entering operand A
// S_B    | operator chosen, entering operand B
// S_DONE | expression complete, outputs frozen until digit or escape

module key_entry_controller (
  input  logic         clk,
  input  logic         rst,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  input  logic         key_valid,
  output logic [3:0]   a_hi,
  output logic [3:0]   a_lo,
  output logic [3:0]   b_hi,
  output logic [3:0]   b_lo,
  output logic [1:0]   op,
  output logic [1:0]   phase,
  output logic         done,
  output logic         result_valid
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t      r_state;
  logic [3:0]  r_a_hi, r_a_lo, r_b_hi, r_b_lo;
  logic [1:0]  r_op;
  logic [1:0]  r_cnt;
  logic [1:0]  r_cnt_a;
  logic [8:0]  r_held;
  logic        r_kv_prev;
  logic        r_done;
  logic        r_rv;

  logic        w_is_digit;
  logic [3:0]  w_digit;
  logic        w_is_op;
  logic [1:0]  w_op_code;
  logic        w_is_enter;
  logic        w_is_bksp;
  logic        w_is_esc;
  logic        w_press;
  logic        w_repeat;
  logic        w_accept;
  logic [3:0]  w_cur_lo;
  logic [3:0]  w_shift_hi;

  always_comb begin
    w_is_digit = 1'b0;
    w_digit    = 4'd0;
    w_is_op    = 1'b0;
    w_op_code  = 2'b00;
    case (last_change)
      9'h045, 9'h070: begin w_is_digit = 1'b1; w_digit = 4'd0; end
      9'h016, 9'h069: begin w_is_digit = 1'b1; w_digit = 4'd1; end
      9'h01E, 9'h072: begin w_is_digit = 1'b1; w_digit = 4'd2; end
      9'h026, 9'h07A: begin w_is_digit = 1'b1; w_digit = 4'd3; end
      9'h025, 9'h06B: begin w_is_digit = 1'b1; w_digit = 4'd4; end
      9'h02E, 9'h073: begin w_is_digit = 1'b1; w_digit = 4'd5; end
      9'h036, 9'h074: begin w_is_digit = 1'b1; w_digit = 4'd6; end
      9'h03D, 9'h06C: begin w_is_digit = 1'b1; w_digit = 4'd7; end
      9'h03E, 9'h075: begin w_is_digit = 1'b1; w_digit = 4'd8; end
      9'h046, 9'h07D: begin w_is_digit = 1'b1; w_digit = 4'd9; end
      9'h079:         begin w_is_op = 1'b1; w_op_code = 2'b00; end
      9'h07B:         begin w_is_op = 1'b1; w_op_code = 2'b01; end
      9'h07C:         begin w_is_op = 1'b1; w_op_code = 2'b10; end
      default: ;
    endcase
  end

  assign w_is_enter = (last_change == 9'h05A) || (last_change == 9'h15A);
  assign w_is_bksp  = (last_change == 9'h066);
  assign w_is_esc   = (last_change == 9'h076);

  // Rising edge of key_valid with the key actually down: a make event.
  assign w_press  = key_valid & ~r_kv_prev & key_down[last_change];
  assign w_repeat = (last_change == r_held) & key_down[r_held];
  assign w_accept = w_press & ~w_repeat &
                    (w_is_digit | w_is_op | w_is_enter | w_is_bksp | w_is_esc);

  assign w_cur_lo   = (r_state == S_B) ? r_b_lo : r_a_lo;
  assign w_shift_hi = (r_cnt == 2'd0) ? 4'd0 : w_cur_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_A;
      r_a_hi    <= 4'd0;
      r_a_lo    <= 4'd0;
      r_b_hi    <= 4'd0;
      r_b_lo    <= 4'd0;
      r_op      <= 2'b00;
      r_cnt     <= 2'd0;
      r_cnt_a   <= 2'd0;
      r_held    <= 9'd0;
      r_kv_prev <= 1'b0;
      r_done    <= 1'b0;
      r_rv      <= 1'b0;
    end else begin
      r_kv_prev <= key_valid;
      r_rv      <= 1'b0;

      // Forget the held code once its key is seen released, so the next
      // make of the same key (which sets key_down again) is not taken as
      // a typematic repeat. Code 0 maps to no key class.
      if (w_accept)
        r_held <= last_change;
      else if (!key_down[r_held])
        r_held <= 9'd0;

      if (w_accept) begin
        if (w_is_esc) begin
          r_state <= S_A;
          r_a_hi  <= 4'd0;
          r_a_lo  <= 4'd0;
          r_b_hi  <= 4'd0;
          r_b_lo  <= 4'd0;
          r_op    <= 2'b00;
          r_cnt   <= 2'd0;
          r_cnt_a <= 2'd0;
          r_done  <= 1'b0;
        end else begin
          case (r_state)
            S_A: begin
              if (w_is_digit && r_cnt != 2'd2) begin
                r_a_hi  <= w_shift_hi;
                r_a_lo  <= w_digit;
                r_cnt   <= r_cnt + 2'd1;
                r_cnt_a <= r_cnt + 2'd1;
              end else if (w_is_op) begin
                r_op    <= w_op_code;
                r_b_hi  <= 4'd0;
                r_b_lo  <= 4'd0;
                r_cnt_a <= r_cnt;
                r_cnt   <= 2'd0;
                r_state <= S_B;
              end else if (w_is_bksp && r_cnt != 2'd0) begin
                r_a_lo  <= r_a_hi;
                r_a_hi  <= 4'd0;
                r_cnt   <= r_cnt - 2'd1;
                r_cnt_a <= r_cnt - 2'd1;
              end
            end
            S_B: begin
              if (w_is_digit && r_cnt != 2'd2) begin
                r_b_hi <= w_shift_hi;
                r_b_lo <= w_digit;
                r_cnt  <= r_cnt + 2'd1;
              end else if (w_is_op && r_cnt == 2'd0) begin
                r_op <= w_op_code;
              end else if (w_is_bksp) begin
                if (r_cnt != 2'd0) begin
                  r_b_lo <= r_b_hi;
                  r_b_hi <= 4'd0;
                  r_cnt  <= r_cnt - 2'd1;
                end else begin
                  // Back out of the operator; resume editing A where it was.
                  r_op    <= 2'b00;
                  r_cnt   <= r_cnt_a;
                  r_state <= S_A;
                end
              end else if (w_is_enter) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_rv    <= 1'b1;
              end
            end
            S_DONE: begin
              if (w_is_digit) begin
                r_a_hi  <= 4'd0;
                r_a_lo  <= w_digit;
                r_b_hi  <= 4'd0;
                r_b_lo  <= 4'd0;
                r_op    <= 2'b00;
                r_cnt   <= 2'd1;
                r_cnt_a <= 2'd1;
                r_state <= S_A;
                r_done  <= 1'b0;
              end
            end
            default: begin
              r_state <= S_A;
              r_done  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign a_hi         = r_a_hi;
  assign a_lo         = r_a_lo;
  assign b_hi         = r_b_hi;
  assign b_lo         = r_b_lo;
  assign op           = r_op;
  assign phase        = r_state;
  assign done         = r_done;
  assign result_valid = r_rv;

endmodule
